// File: rtl/id_issue_queue.sv
// Decode-to-execute issue queue: DEPTH-entry circular buffer with valid/ready on both sides,
// NOP-masked bubbles, whole-queue flush and exception enqueue lock. Optional ID_QUEUE_BYPASS_EN.
module id_issue_queue #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH         = 18,
    parameter int DEPTH              = 4,
    parameter int CNT_WIDTH          = $clog2(DEPTH + 1)
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          ID_Flush,
    input  logic                          In_valid,
    output logic                          In_ready,
    input  logic [REG_DATA_WIDTH-1:0]     In_PC,
    input  logic [REG_DATA_WIDTH-1:0]     In_PC_dest,
    input  logic [REG_DATA_WIDTH-1:0]     In_Immediate_1,
    input  logic [REG_DATA_WIDTH-1:0]     In_Immediate_2,
    input  logic [CTRL_WIDTH-1:0]         In_Ctrl,
    input  logic [REGFILE_ADDR_WIDTH-1:0] In_Rd_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] In_Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] In_Rs2_addr,
    input  logic                          In_Exception,
    output logic                          Out_valid,
    input  logic                          Out_ready,
    output logic [REG_DATA_WIDTH-1:0]     Out_PC,
    output logic [REG_DATA_WIDTH-1:0]     Out_PC_dest,
    output logic [REG_DATA_WIDTH-1:0]     Out_Immediate_1,
    output logic [REG_DATA_WIDTH-1:0]     Out_Immediate_2,
    output logic [CTRL_WIDTH-1:0]         Out_Ctrl,
    output logic [REGFILE_ADDR_WIDTH-1:0] Out_Rd_addr,
    output logic [REGFILE_ADDR_WIDTH-1:0] Out_Rs1_addr,
    output logic [REGFILE_ADDR_WIDTH-1:0] Out_Rs2_addr,
    output logic                          Out_Exception,
    output logic [CNT_WIDTH-1:0]          Count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 4 * REG_DATA_WIDTH + CTRL_WIDTH + 3 * REGFILE_ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [ENTRY_W-1:0]            mem [DEPTH];
    logic [ENTRY_W-1:0]            in_entry;
    logic [ENTRY_W-1:0]            head_entry;
    logic [ENTRY_W-1:0]            out_entry;
    logic [PTR_W-1:0]              rd_ptr;
    logic [PTR_W-1:0]              wr_ptr;
    logic [CNT_WIDTH-1:0]          cnt;
    logic                          exc_lock;
    logic                          empty;
    logic                          enq;
    logic                          deq;
    logic                          store;
    logic                          pop;
    logic [CTRL_WIDTH-1:0]         head_ctrl;
    logic [REGFILE_ADDR_WIDTH-1:0] head_rd;
    logic                          head_exc;

    assign in_entry   = {In_PC, In_PC_dest, In_Immediate_1, In_Immediate_2, In_Ctrl,
                         In_Rd_addr, In_Rs1_addr, In_Rs2_addr, In_Exception};
    assign head_entry = mem[rd_ptr];
    assign empty      = (cnt == '0);

    // Deliberately independent of Out_ready: a full queue refuses input even while draining.
    assign In_ready = (cnt != FULL_CNT) && !exc_lock && !ID_Flush;
    assign enq      = In_valid && In_ready;
    assign deq      = Out_valid && Out_ready;

`ifdef ID_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass    = empty && In_valid && !ID_Flush && !exc_lock;
    assign Out_valid = !empty || bypass;
    assign out_entry = empty ? in_entry : head_entry;
    // A bundle consumed straight through the bypass never touches the array.
    assign store     = enq && !(bypass && Out_ready);
    assign pop       = deq && !empty;
`else
    assign Out_valid = !empty;
    assign out_entry = head_entry;
    assign store     = enq;
    assign pop       = deq;
`endif

    assign {Out_PC, Out_PC_dest, Out_Immediate_1, Out_Immediate_2, head_ctrl,
            head_rd, Out_Rs1_addr, Out_Rs2_addr, head_exc} = out_entry;

    // Bubbles must decode as a NOP downstream.
    assign Out_Ctrl      = Out_valid ? head_ctrl : '0;
    assign Out_Rd_addr   = Out_valid ? head_rd   : '0;
    assign Out_Exception = Out_valid && head_exc;
    assign Count         = cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            exc_lock <= 1'b0;
        end else if (ID_Flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            exc_lock <= 1'b0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (store && !pop)
                cnt <= cnt + CNT_WIDTH'(1);
            else if (!store && pop)
                cnt <= cnt - CNT_WIDTH'(1);
            if (enq && In_Exception) exc_lock <= 1'b1;
        end
    end

    // Payload storage carries no reset; entries are only visible while counted valid.
    always_ff @(posedge Clk) begin
        if (store) mem[wr_ptr] <= in_entry;
    end

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue (DEPTH=4): vector table, hand sequences and a queue-based random model.
module tb_id_issue_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcd;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [17:0] ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        exc;
    } bundle_t;

    typedef struct {
        logic        iv;
        logic        fl;
        logic        ordy;
        logic [31:0] pc;
        logic        exc;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic        e_exc;
        int          e_cnt;
    } vec_t;

    logic        Clk;
    logic        Reset_n;
    logic        ID_Flush;
    logic        In_valid;
    logic        In_ready;
    bundle_t     in_b;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] Out_PC, Out_PC_dest, Out_Immediate_1, Out_Immediate_2;
    logic [17:0] Out_Ctrl;
    logic [4:0]  Out_Rd_addr, Out_Rs1_addr, Out_Rs2_addr;
    logic        Out_Exception;
    logic [2:0]  Count;
    bundle_t     out_b;

    int n_pass  = 0;
    int n_total = 0;

    id_issue_queue #(.DEPTH(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ID_Flush(ID_Flush),
        .In_valid(In_valid), .In_ready(In_ready),
        .In_PC(in_b.pc), .In_PC_dest(in_b.pcd), .In_Immediate_1(in_b.i1), .In_Immediate_2(in_b.i2),
        .In_Ctrl(in_b.ctrl), .In_Rd_addr(in_b.rd), .In_Rs1_addr(in_b.rs1), .In_Rs2_addr(in_b.rs2),
        .In_Exception(in_b.exc),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Out_PC(Out_PC), .Out_PC_dest(Out_PC_dest), .Out_Immediate_1(Out_Immediate_1),
        .Out_Immediate_2(Out_Immediate_2), .Out_Ctrl(Out_Ctrl), .Out_Rd_addr(Out_Rd_addr),
        .Out_Rs1_addr(Out_Rs1_addr), .Out_Rs2_addr(Out_Rs2_addr), .Out_Exception(Out_Exception),
        .Count(Count)
    );

    assign out_b = {Out_PC, Out_PC_dest, Out_Immediate_1, Out_Immediate_2, Out_Ctrl,
                    Out_Rd_addr, Out_Rs1_addr, Out_Rs2_addr, Out_Exception};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Payload derived from the PC so every field of a head entry is distinguishable.
    function automatic bundle_t mk(input logic [31:0] pc, input logic exc);
        bundle_t b;
        b.pc   = pc;
        b.pcd  = pc + 32'h1000;
        b.i1   = ~pc;
        b.i2   = pc ^ 32'hA5A5_A5A5;
        b.ctrl = pc[17:0] ^ 18'h2AAAA;
        b.rd   = pc[6:2] ^ 5'h15;
        b.rs1  = pc[4:0];
        b.rs2  = pc[9:5];
        b.exc  = exc;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input logic e_ov, input bundle_t e_b);
        chk({nm, "_valid"}, 192'(Out_valid), 192'(e_ov));
        if (e_ov) chk({nm, "_head"}, 192'(out_b), 192'(e_b));
        else      chk({nm, "_nop"}, 192'({Out_Ctrl, Out_Rd_addr, Out_Exception}), 192'(0));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic iv, input logic fl, input logic ordy, input bundle_t b);
        @(negedge Clk);
        In_valid  = iv;
        ID_Flush  = fl;
        Out_ready = ordy;
        in_b      = b;
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        In_valid = 1'b0; ID_Flush = 1'b0; Out_ready = 1'b0; in_b = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

`ifndef ID_QUEUE_BYPASS_EN
    vec_t    vecs [25];
    bundle_t model_q [$];
    logic    model_lock;
`endif

    initial begin
        do_reset();
`ifndef ID_QUEUE_BYPASS_EN
        //           iv    fl    or    pc            exc   ir    ov    e_pc          e_exc cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h100,      1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h104,      1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h108,      1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 2};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h10C,      1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 3};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h110,      1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 4};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h110,      1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 4};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h104,      1'b0, 3};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h108,      1'b0, 2};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h10C,      1'b0, 1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h500,      1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h504,      1'b0, 1'b1, 1'b1, 32'h500,      1'b0, 1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h508,      1'b0, 1'b1, 1'b1, 32'h500,      1'b0, 2};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h50C,      1'b0, 1'b0, 1'b1, 32'h500,      1'b0, 3};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h200,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h204,      1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 1};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 32'h204,      1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 1};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 32'h204,      1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 0};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 32'h208,      1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h208,      1'b0, 1};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].iv, vecs[i].fl, vecs[i].ordy, mk(vecs[i].pc, vecs[i].exc));
            chk($sformatf("vec%0d_in_ready", i), 192'(In_ready), 192'(vecs[i].e_ir));
            chk($sformatf("vec%0d_count", i), 192'(Count), 192'(vecs[i].e_cnt));
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, mk(vecs[i].e_pc, vecs[i].e_exc));
        end

        // Sustained streaming: occupancy holds at 1 and order survives pointer wrap.
        for (int i = 0; i < 11; i++) begin
            drive(i < 10, 1'b0, 1'b1, mk(32'h600 + 32'(4 * i), 1'b0));
            chk($sformatf("stream%0d_count", i), 192'(Count), 192'(i > 0 ? 1 : 0));
            chk_out($sformatf("stream%0d", i), i > 0, mk(32'h600 + 32'(4 * (i - 1)), 1'b0));
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("stream_drained", 192'(Count), 192'(0));

        // Asynchronous reset in the middle of a transfer.
        drive(1'b1, 1'b0, 1'b0, mk(32'h700, 1'b0));
        drive(1'b1, 1'b0, 1'b0, mk(32'h704, 1'b1));
        drive(1'b1, 1'b0, 1'b0, mk(32'h708, 1'b0));
        chk("prereset_count", 192'(Count), 192'(2));
        Reset_n = 1'b0;
        #1;
        chk("async_reset_count", 192'(Count), 192'(0));
        chk("async_reset_in_ready", 192'(In_ready), 192'(1));
        chk_out("async_reset", 1'b0, '0);
        In_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            chk_out($sformatf("postreset%0d", i), 1'b0, '0);
        end

        // Randomised traffic against a queue model.
        model_lock = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic    iv, fl, ordy, e_ir, e_ov;
            bundle_t b;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            b    = {$urandom, $urandom, $urandom, $urandom, 18'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), ($urandom_range(0, 15) == 0)};
            drive(iv, fl, ordy, b);
            e_ir = (model_q.size() < 4) && !model_lock && !fl;
            e_ov = (model_q.size() > 0);
            chk($sformatf("rnd%0d_in_ready", n), 192'(In_ready), 192'(e_ir));
            chk($sformatf("rnd%0d_count", n), 192'(Count), 192'(model_q.size()));
            chk_out($sformatf("rnd%0d", n), e_ov, e_ov ? model_q[0] : '0);
            if (fl) begin
                model_q.delete();
                model_lock = 1'b0;
            end else begin
                if (e_ov && ordy) void'(model_q.pop_front());
                if (iv && e_ir) begin
                    model_q.push_back(b);
                    if (b.exc) model_lock = 1'b1;
                end
            end
        end
`else
        // Bypass build: empty queue passes the bundle through in the same cycle.
        drive(1'b0, 1'b0, 1'b1, '0);
        chk("byp_reset_in_ready", 192'(In_ready), 192'(1));
        chk("byp_reset_count", 192'(Count), 192'(0));
        chk_out("byp_reset", 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, mk(32'h300, 1'b0));
        chk_out("byp_pass", 1'b1, mk(32'h300, 1'b0));
        chk("byp_pass_count", 192'(Count), 192'(0));
        drive(1'b0, 1'b0, 1'b1, '0);
        chk("byp_after_count", 192'(Count), 192'(0));
        chk_out("byp_after", 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, mk(32'h310, 1'b0));
        chk_out("byp_hold", 1'b1, mk(32'h310, 1'b0));
        drive(1'b0, 1'b0, 1'b1, '0);
        chk("byp_stored_count", 192'(Count), 192'(1));
        chk_out("byp_stored", 1'b1, mk(32'h310, 1'b0));
        drive(1'b1, 1'b0, 1'b1, mk(32'h304, 1'b1));
        chk_out("byp_exc", 1'b1, mk(32'h304, 1'b1));
        drive(1'b1, 1'b0, 1'b1, mk(32'h308, 1'b0));
        chk("byp_locked_in_ready", 192'(In_ready), 192'(0));
        chk_out("byp_locked", 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("byp_unlocked_in_ready", 192'(In_ready), 192'(1));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_issue_queue.md
# id_issue_queue

Parametrised decode-to-execute buffer replacing the single-entry ID/EX register. It holds up to DEPTH decoded instruction bundles in a circular queue, with valid/ready handshakes on both sides instead of a global stall. A bubble at the output always reads as a NOP, a whole-queue flush is supported, and enqueue is locked after an exception is accepted. It sits between the decoder/regfile read logic and the execute stage.

## Interface
Parameters:
- REG_DATA_WIDTH, 32, width of PC, immediates and PC destination
- REGFILE_ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 18, packed control bundle: ALU_source_sel, ALU_op, Branch_op, Branch_flag, Mem_wr_en, Mem_rd_en, RegFile_wr_en, MemToReg, Jump, Mem_op
- DEPTH, 4, number of entries; power of two, ≥2
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy counter

Ports:
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ID_Flush  in  1  discard every entry and the current enqueue
- In_valid  in  1  decoder presents a bundle
- In_ready  out  1  queue accepts the bundle this cycle
- In_PC, In_PC_dest, In_Immediate_1, In_Immediate_2  in  REG_DATA_WIDTH each  payload
- In_Ctrl  in  CTRL_WIDTH  payload control bundle
- In_Rd_addr, In_Rs1_addr, In_Rs2_addr  in  REGFILE_ADDR_WIDTH each  payload
- In_Exception  in  1  payload exception flag
- Out_valid  out  1  head entry is valid
- Out_ready  in  1  execute stage consumes the head
- Out_PC, Out_PC_dest, Out_Immediate_1, Out_Immediate_2, Out_Ctrl, Out_Rd_addr, Out_Rs1_addr, Out_Rs2_addr, Out_Exception  out  matching widths  head payload
- Count  out  CNT_WIDTH  current occupancy

## Operation
- Storage: DEPTH-entry array, rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and a Count register.
- Enqueue fires when In_valid && In_ready. Dequeue fires when Out_valid && Out_ready.
- In_ready = (Count != DEPTH) && !exc_lock && !ID_Flush. In_ready does not depend combinationally on Out_ready, so a full queue refuses input even in a cycle that dequeues.
- Simultaneous enqueue and dequeue: Count is unchanged and both pointers advance.
- Output masking:
  - When Out_valid=0: Out_Ctrl, Out_Rd_addr and Out_Exception are forced to 0, so the bubble is a NOP.
  - Other payload outputs show the stale head contents; their value is don't-care.
- Exception lock:
  - exc_lock sets on the edge where an entry with In_Exception=1 is enqueued.
  - While exc_lock=1, no further enqueue is accepted and dequeue continues normally.
  - exc_lock clears only on ID_Flush or reset.
- Flush has top priority. On the edge where ID_Flush=1: Count←0, both pointers←0, exc_lock←0. Any enqueue or dequeue in that cycle is discarded.
- Payload array contents are not reset; they are unreadable while their entry is invalid.

## Timing
- Reset (asynchronous, takes effect immediately): Count=0, pointers=0, exc_lock=0, Out_valid=0, In_ready=1, Out_Ctrl=0, Out_Rd_addr=0, Out_Exception=0.
- Latency: a bundle enqueued at edge N is presented at the output with Out_valid=1 from cycle N+1 (no bypass).
- Throughput: one enqueue and one dequeue per cycle sustained; at steady state Count stays constant.
- Empty: Out_valid=0.
- Full (Count=DEPTH): In_ready=0.
- Reset asserted mid-transfer: all state is lost and nothing is committed downstream afterwards.

## Configuration
- ID_QUEUE_BYPASS_EN defined:
  - When Count=0, In_valid=1, Out_ready=1, exc_lock=0 and ID_Flush=0, the In_* payload appears combinationally on Out_* with Out_valid=1.
  - That bundle is consumed without being written into the array, giving 0-cycle latency.
  - When Count=0, Out_valid follows In_valid, gated by !ID_Flush && !exc_lock.
  - An exception bundle passed through the bypass still sets exc_lock.
- ID_QUEUE_BYPASS_EN undefined: the output is purely registered, with 1-cycle minimum latency as described in Timing.

## Test plan
All scenarios use DEPTH=4 and no bypass unless stated.
- Reset, then hold In_valid=0 → Out_valid=0, Out_Ctrl=0, Out_Rd_addr=0, Count=0, In_ready=1.
- Enqueue PCs 0x100, 0x104, 0x108, 0x10C with Out_ready=0 → Count=4, In_ready=0. Then raise Out_ready → heads appear in order 0x100…0x10C, one per cycle, and Count reaches 0.
- Stream 10 bundles with In_valid=1 and Out_ready=1 continuously → Count stays at 1, no bundle lost, pointers wrap after 4 entries, and the output order matches the input order.
- Queue holds 3 entries and ID_Flush=1 with In_valid=1 → next cycle Count=0, Out_valid=0, and the flushed-cycle bundle never appears at the output.
- Enqueue 0x200 with In_Exception=1 followed by 0x204 → 0x204 is refused (In_ready=0) and 0x200 drains with Out_Exception=1. After ID_Flush, In_ready=1 again.
- With ID_QUEUE_BYPASS_EN, empty queue, Out_ready=1, In_PC=0x300 → Out_PC=0x300 with Out_valid=1 in the same cycle, and Count remains 0.
